// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Holds the FSM state encoding and the latency calculation.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of RUN cycles needed to sweep all slices.
  function automatic int latency(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from gate primitives.
// Chained DIGIT times to form the per-cycle slice adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output wire  s,
  output wire  cout
);

  wire p;
  wire g;
  wire t;

  xor u_x0 (p, a, b);
  xor u_x1 (s, p, cin);
  and u_a0 (g, a, b);
  and u_a1 (t, p, cin);
  or  u_o0 (cout, g, t);

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB first.
// Results are registered and held in DONE until the next start.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = latency(WIDTH, DIGIT);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             sub_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] b_x;
  logic [DIGIT-1:0] slice;
  logic [DIGIT:0]   c;
  logic             last;

  // Subtraction adds ~b; the +1 comes from the carry seeded at start.
  assign b_x  = b_sh[DIGIT-1:0] ^ {DIGIT{sub_r}};
  assign c[0] = carry;
  assign last = (cnt == LAST);

  for (genvar j = 0; j < DIGIT; j++) begin : g_fa
    full_adder u_fa (
      .a    (a_sh[j]),
      .b    (b_x[j]),
      .cin  (c[j]),
      .s    (slice[j]),
      .cout (c[j+1])
    );
  end

  // Result register fills from the top; after N shifts it is aligned.
  for (genvar i = 0; i < WIDTH - DIGIT; i++) begin : g_keep
    assign acc_next[i] = acc[i+DIGIT];
  end
  for (genvar k = 0; k < DIGIT; k++) begin : g_ins
    assign acc_next[WIDTH-DIGIT+k] = slice[k];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            a_sh  <= a;
            b_sh  <= b;
            sub_r <= sub;
            carry <= sub;
            cnt   <= '0;
            acc   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          acc   <= acc_next;
          carry <= c[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= acc_next;
            cout  <= c[DIGIT];
            ovf   <= c[DIGIT] ^ c[DIGIT-1];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at DIGIT = 1, 4 and 8.
// Expected results come from plain integer arithmetic.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;

  logic       busy_v [3];
  logic       done_v [3];
  logic       cout_v [3];
  logic       ovf_v  [3];
  logic [7:0] sum_v  [3];

  int n_v [3] = '{8, 2, 1};
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]),
    .cout(cout_v[0]), .ovf(ovf_v[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]),
    .cout(cout_v[1]), .ovf(ovf_v[1])
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]),
    .cout(cout_v[2]), .ovf(ovf_v[2])
  );

  // Reference: {ovf, cout, sum} from integer add/subtract.
  function automatic logic [9:0] ref_model(
    input logic [7:0] x, input logic [7:0] y, input logic s
  );
    int ux, uy, r, sr;
    logic c, o;
    ux = int'(x);
    uy = int'(y);
    if (s) begin
      r  = ux - uy;
      c  = (ux >= uy);
      sr = int'($signed(x)) - int'($signed(y));
    end else begin
      r  = ux + uy;
      c  = (r > 255);
      sr = int'($signed(x)) + int'($signed(y));
    end
    o = (sr > 127) || (sr < -128);
    return {o, c, 8'(r)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated operation, checked on every DUT selected by mask.
  task automatic run_op(
    input logic [7:0] ta, input logic [7:0] tb_,
    input logic ts, input logic [2:0] mask
  );
    logic [9:0] e;
    e = ref_model(ta, tb_, ts);
    @(negedge clk);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    for (int j = 0; j <= 10; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      for (int d = 0; d < 3; d++) begin
        if (mask[d]) begin
          checks++;
          if (busy_v[d] !== (j < n_v[d])) begin
            errors++;
            $display("FAIL busy d%0d j%0d: got %b want %b",
                     d, j, busy_v[d], (j < n_v[d]));
          end
          checks++;
          if (done_v[d] !== (j == n_v[d])) begin
            errors++;
            $display("FAIL done d%0d j%0d: got %b want %b",
                     d, j, done_v[d], (j == n_v[d]));
          end
          if (j >= n_v[d]) begin
            checks++;
            if ({ovf_v[d], cout_v[d], sum_v[d]} !== e) begin
              errors++;
              $display("FAIL result d%0d j%0d %h%s%h: got o%b c%b %h want o%b c%b %h",
                       d, j, ta, ts ? "-" : "+", tb_, ovf_v[d], cout_v[d],
                       sum_v[d], e[9], e[8], e[7:0]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; sub = 1'b0; a = 8'h7F; b = 8'h01;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({busy_v[d], done_v[d], ovf_v[d], cout_v[d], sum_v[d]} !== 12'h000) begin
          errors++;
          $display("FAIL reset d%0d j%0d: got b%b d%b o%b c%b %h want all 0",
                   d, j, busy_v[d], done_v[d], ovf_v[d], cout_v[d], sum_v[d]);
        end
      end
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_vectors();
    do_reset();
    run_op(8'h7F, 8'h01, 1'b0, 3'b111);
    run_op(8'hFF, 8'h01, 1'b0, 3'b111);
    run_op(8'h05, 8'h07, 1'b1, 3'b111);
    run_op(8'h80, 8'h80, 1'b0, 3'b111);
    run_op(8'h80, 8'h01, 1'b1, 3'b111);
    run_op(8'h00, 8'h00, 1'b1, 3'b111);
  endtask

  task automatic test_start_ignored();
    logic [9:0] e;
    int pulses;
    do_reset();
    e = ref_model(8'h3C, 8'h5A, 1'b0);
    pulses = 0;
    @(negedge clk);
    a = 8'h3C; b = 8'h5A; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      if (j == 2) begin
        a = 8'h11; b = 8'h22; sub = 1'b1; start = 1'b1;
      end
      if (j == 3) start = 1'b0;
      if (done_v[0] === 1'b1) pulses++;
      if (j >= 8) begin
        checks++;
        if ({ovf_v[0], cout_v[0], sum_v[0]} !== e) begin
          errors++;
          $display("FAIL ignore_result j%0d: got %h want %h",
                   j, {ovf_v[0], cout_v[0], sum_v[0]}, e);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL ignore_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    do_reset();
    pulses = 0;
    @(negedge clk);
    a = 8'h7F; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 0; j <= 14; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      if (j == 3) rst = 1'b1;
      if (j == 4) begin
        rst = 1'b0;
        checks++;
        if ({busy_v[0], sum_v[0]} !== 9'h000) begin
          errors++;
          $display("FAIL abort_state: got busy %b sum %h want 0 00",
                   busy_v[0], sum_v[0]);
        end
      end
      if (done_v[0] === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_pulses: got %0d want 0", pulses);
    end
    run_op(8'h12, 8'h34, 1'b0, 3'b111);
  endtask

  task automatic test_back_to_back();
    logic [7:0] x1, y1, x2, y2;
    logic s1, s2;
    logic [9:0] e1, e2;
    int n;
    for (int d = 0; d < 3; d++) begin
      do_reset();
      n = n_v[d];
      x1 = 8'($urandom); y1 = 8'($urandom); s1 = 1'($urandom);
      x2 = 8'($urandom); y2 = 8'($urandom); s2 = 1'($urandom);
      e1 = ref_model(x1, y1, s1);
      e2 = ref_model(x2, y2, s2);
      @(negedge clk);
      a = x1; b = y1; sub = s1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int j = 0; j <= 2 * n + 3; j++) begin
        if (j > 0) begin
          @(posedge clk);
          #1;
        end
        checks++;
        if (busy_v[d] !== ((j < n) || (j > n && j <= 2 * n))) begin
          errors++;
          $display("FAIL b2b_busy d%0d j%0d: got %b", d, j, busy_v[d]);
        end
        checks++;
        if (done_v[d] !== ((j == n) || (j == 2 * n + 1))) begin
          errors++;
          $display("FAIL b2b_done d%0d j%0d: got %b", d, j, done_v[d]);
        end
        if (j == n) begin
          checks++;
          if ({ovf_v[d], cout_v[d], sum_v[d]} !== e1) begin
            errors++;
            $display("FAIL b2b_first d%0d: got %h want %h",
                     d, {ovf_v[d], cout_v[d], sum_v[d]}, e1);
          end
          a = x2; b = y2; sub = s2; start = 1'b1;
        end
        if (j == n + 1) begin
          start = 1'b0;
          a = 8'($urandom); b = 8'($urandom);
        end
        if (j >= 2 * n + 1) begin
          checks++;
          if ({ovf_v[d], cout_v[d], sum_v[d]} !== e2) begin
            errors++;
            $display("FAIL b2b_second d%0d j%0d: got %h want %h",
                     d, j, {ovf_v[d], cout_v[d], sum_v[d]}, e2);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 120; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 3'b111);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    test_reset();
    test_vectors();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
